seg_scan: RTL and testbench

Time-multiplexed scan driver for an 8-digit, 7-segment LED display with shared segment lines and per-digit common drivers. It sits directly downstream of the memory-mapped segment controller and consumes its eight decoded per-digit patterns. It emits one digit at a time with a dead-time guard and programmable brightness (PWM duty), which lets a board with a shared segment bus show all eight digits.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_prescale.sv | 25 ++
 rtl/seg_scan.sv | 95 +++++++++
 tb/tb_seg_scan.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment display blocks.
package seg_pkg;

  localparam int SUBSLOTS   = 16;
  localparam int BRIGHT_W   = 4;
  localparam int MAX_DIGITS = 32;
  localparam int DIG_IDX_W  = 5;

  typedef struct packed {
    logic                en;
    logic [BRIGHT_W-1:0] bright;
  } slot_cfg_t;

  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [DIG_IDX_W-1:0] idx);
    digit_onehot = MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg_prescale.sv
// Free-running prescaler: tick_o is high on the last cycle of every PRESCALE-cycle period.
module seg_prescale #(
  parameter int PRESCALE = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CNT_W-1:0] pre_q, pre_d;

  assign tick_o = (pre_q == CNT_W'(PRESCALE - 1));

  always_comb begin
    pre_d = tick_o ? '0 : pre_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment scan driver: one digit per slot, dark sub-slot 0, PWM brightness.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SEG            = 7,
  parameter int DIGITS         = 8,
  parameter int PRESCALE       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIGITS*SEG-1:0] segs_i,
  input  logic [DIGITS-1:0]     en_i,
  input  logic [3:0]            bright_i,
  output logic [SEG-1:0]        seg_o,
  output logic [DIGITS-1:0]     dig_o,
  output logic                  frame_o
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SEG-1:0]    SEG_OFF  = {SEG{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  logic tick;

  seg_prescale #(.PRESCALE(PRESCALE)) u_prescale (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .tick_o (tick)
  );

  logic [BRIGHT_W-1:0] sub_q, sub_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SEG-1:0]      pat_q, pat_d;
  slot_cfg_t           cfg_q, cfg_d;
  logic [SEG-1:0]      seg_q, seg_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic                frame_q, frame_d;
  logic                slot_end;
  logic                lit;

  always_comb begin
    slot_end = tick && (sub_q == BRIGHT_W'(SUBSLOTS - 1));
    sub_d    = tick ? sub_q + BRIGHT_W'(1) : sub_q;

    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    // Latch tracks the inputs through the dark sub-slot, then freezes for the lit part.
    pat_d = pat_q;
    cfg_d = cfg_q;
    if (sub_q == '0) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          pat_d  = segs_i[k*SEG +: SEG];
          cfg_d.en = en_i[k];
        end
      end
      cfg_d.bright = bright_i;
    end

    lit = cfg_q.en && (sub_q != '0) && (sub_q <= cfg_q.bright);

    seg_d   = (lit ? pat_q : '0) ^ SEG_OFF;
    dig_d   = (lit ? DIGITS'(digit_onehot(DIG_IDX_W'(idx_q))) : '0) ^ DIG_OFF;
    frame_d = slot_end && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sub_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      cfg_q   <= '0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
      frame_q <= 1'b0;
    end else begin
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      cfg_q   <= cfg_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  assign seg_o   = seg_q;
  assign dig_o   = dig_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: time-based reference model plus directed literal checks.
module tb_seg_scan;

  localparam int SEG      = 7;
  localparam int DIGITS   = 8;
  localparam int PRESCALE = 4;
  localparam int SLOT     = 16 * PRESCALE;
  localparam int FRAME    = SLOT * DIGITS;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic [DIGITS*SEG-1:0] segs_i;
  logic [DIGITS-1:0]     en_i;
  logic [3:0]            bright_i;
  logic [SEG-1:0]        seg_o;
  logic [DIGITS-1:0]     dig_o;
  logic                  frame_o;

  always #5 clk = ~clk;

  seg_scan #(
    .SEG(SEG), .DIGITS(DIGITS), .PRESCALE(PRESCALE),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .segs_i  (segs_i),
    .en_i    (en_i),
    .bright_i(bright_i),
    .seg_o   (seg_o),
    .dig_o   (dig_o),
    .frame_o (frame_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: position in the frame is just cycles since reset modulo the frame length.
  int             cnt;
  int             pos, sub, dig;
  bit             m_lit;
  logic [SEG-1:0] m_pat;
  bit             m_en;
  int             m_bright;
  logic [SEG-1:0] exp_seg;
  logic [7:0]     exp_dig;
  logic           exp_frame;
  bit             chk_en = 0;

  always @(posedge clk) begin
    if (rst_i) begin
      cnt = 0; m_pat = '0; m_en = 0; m_bright = 0;
      exp_seg = 7'h7F; exp_dig = 8'hFF; exp_frame = 1'b0;
    end else begin
      pos = cnt % FRAME;
      sub = (pos / PRESCALE) % 16;
      dig = pos / SLOT;
      m_lit = m_en && (sub != 0) && (sub <= m_bright);
      exp_seg   = m_lit ? ~m_pat : 7'h7F;
      exp_dig   = m_lit ? ~(8'h01 << dig) : 8'hFF;
      exp_frame = (pos == FRAME - 1);
      if (sub == 0) begin
        m_pat = segs_i[dig*SEG +: SEG];
        m_en = en_i[dig];
        m_bright = int'(bright_i);
      end
      cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_seg",   seg_o,   exp_seg);
      check("model_dig",   dig_o,   exp_dig);
      check("model_frame", frame_o, exp_frame);
    end
  end

  // e = negedges since reset release, i.e. clock edges the counters have seen.
  int e;
  int on_cnt[DIGITS];
  int frames, first_fr, second_fr;

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic measure(input int n);
    for (int k = 0; k < DIGITS; k++) on_cnt[k] = 0;
    frames = 0; first_fr = -1; second_fr = -1;
    for (int i = 0; i < n; i++) begin
      cyc(1);
      for (int k = 0; k < DIGITS; k++) if (dig_o[k] == 1'b0) on_cnt[k]++;
      if (frame_o) begin
        frames++;
        if (first_fr < 0) first_fr = e;
        else if (second_fr < 0) second_fr = e;
      end
    end
  endtask

  task automatic check_release();
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      if (i < 5) check("dark_before_first_on", dig_o, 8'hFF);
    end
    check("first_on_dig", dig_o, 8'hFE);
  endtask

  initial begin
    rst_i = 1'b1;
    segs_i = '0;
    segs_i[0*SEG +: SEG] = 7'h3F;
    segs_i[1*SEG +: SEG] = 7'h06;
    en_i = 8'hFF;
    bright_i = 4'd15;
    e = 0;

    @(negedge clk);
    chk_en = 1;
    repeat (2) @(negedge clk);
    check("reset_seg",   seg_o,   7'h7F);
    check("reset_dig",   dig_o,   8'hFF);
    check("reset_frame", frame_o, 1'b0);

    rst_i = 1'b0; e = 0;
    check_release();
    check("first_on_seg", seg_o, 7'h40);
    cyc(59);
    check("d0_last_on", dig_o, 8'hFE);
    cyc(1);
    check("d0_d1_gap", dig_o, 8'hFF);
    cyc(4);
    check("d1_on_dig", dig_o, 8'hFD);
    check("d1_on_seg", seg_o, 7'h79);

    measure(FRAME);
    check("full_on_d0", on_cnt[0], 60);
    check("full_on_d1", on_cnt[1], 60);
    check("full_frames", frames, 1);

    bright_i = 4'd4;
    cyc(FRAME);
    measure(FRAME);
    check("b4_on_d0", on_cnt[0], 16);
    check("b4_on_d5", on_cnt[5], 16);

    bright_i = 4'd0;
    cyc(FRAME);
    measure(2 * FRAME + 8);
    check("b0_on_d0", on_cnt[0], 0);
    check("b0_on_d7", on_cnt[7], 0);
    check("b0_frames", frames, 2);
    check("b0_frame_period", second_fr - first_fr, FRAME);

    en_i = 8'h0F;
    bright_i = 4'd15;
    cyc(FRAME);
    measure(2 * FRAME + 8);
    check("mask_on_d3", on_cnt[3], 120);
    check("mask_on_d4", on_cnt[4], 0);
    check("mask_on_d7", on_cnt[7], 0);
    check("mask_frame_period", second_fr - first_fr, FRAME);

    while ((e % FRAME) != 5 * PRESCALE) cyc(1);
    segs_i[0*SEG +: SEG] = 7'h5B;
    cyc(10);
    check("midslot_hold_seg", seg_o, 7'h40);
    while ((e % FRAME) != 5) cyc(1);
    check("midslot_new_dig", dig_o, 8'hFE);
    check("midslot_new_seg", seg_o, 7'h24);

    while ((e % FRAME) != 3 * SLOT + 10) cyc(1);
    check("d3_lit_before_rst", dig_o, 8'hF7);
    rst_i = 1'b1;
    cyc(1);
    check("rst_mid_dig",   dig_o,   8'hFF);
    check("rst_mid_seg",   seg_o,   7'h7F);
    check("rst_mid_frame", frame_o, 1'b0);
    cyc(1);
    rst_i = 1'b0; e = 0;
    check_release();
    check("restart_seg", seg_o, 7'h24);
    cyc(100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
